// File: rtl/tile_game_if.sv
// Game-controller bus: start/keystroke inputs, tile ROM port, and score/status outputs.
// master = the round sequencer, slave = its surroundings (PS/2 decoder, ROM, VGA/LEDs).
interface tile_game_if;
  logic       start;
  logic       key_valid;
  logic [7:0] key_code;
  logic [6:0] song_addr;
  logic [7:0] song_data;
  logic [7:0] expected;
  logic [1:0] state;
  logic [9:0] score;
  logic [1:0] lives;
  logic       hit_pulse;
  logic       miss_pulse;
  logic       won;

  modport master (
    input  start, key_valid, key_code, song_data,
    output song_addr, expected, state, score, lives, hit_pulse, miss_pulse, won
  );

  modport slave (
    output start, key_valid, key_code, song_data,
    input  song_addr, expected, state, score, lives, hit_pulse, miss_pulse, won
  );
endinterface

// File: rtl/tile_game_ctrl.sv
// One round of piano tiles: beat-stepped tile ROM, one scoring window per tile,
// keystroke judging, score and lives bookkeeping.
module tile_game_ctrl #(
  parameter int unsigned TICK_CYCLES     = 16_666_666,
  parameter int unsigned SONG_LEN        = 76,
  parameter int unsigned LIVES_INIT      = 3,
  parameter int unsigned COUNTDOWN_BEATS = 3,
  parameter logic [7:0]  EMPTY           = 8'h05
) (
  input logic         CLOCK_50,
  input logic         reset,
  tile_game_if.master bus
);

  localparam int unsigned CW  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned CDW = $clog2(COUNTDOWN_BEATS + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COUNTDOWN = 2'd1,
    S_PLAY      = 2'd2,
    S_OVER      = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CDW-1:0] cd_q, cd_d;
  logic [6:0]     song_addr_q, song_addr_d;
  logic [7:0]     expected_q, expected_d;
  logic           answered_q, answered_d;
  logic [9:0]     score_q, score_d;
  logic [1:0]     lives_q, lives_d;
  logic           hit_q, hit_d;
  logic           miss_q, miss_d;

  logic running, beat, hit_now, key_miss, timeout, miss_now;

  assign running  = (state_q == S_COUNTDOWN) || (state_q == S_PLAY);
  assign beat     = running && (cnt_q == CW'(TICK_CYCLES - 1));
  // A key on the beat cycle is judged against the outgoing tile, so a hit there
  // also cancels that window's timeout.
  assign hit_now  = (state_q == S_PLAY) && bus.key_valid && !answered_q &&
                    (expected_q != EMPTY) && (bus.key_code == expected_q);
  assign key_miss = (state_q == S_PLAY) && bus.key_valid && !hit_now;
  assign timeout  = (state_q == S_PLAY) && beat && (expected_q != EMPTY) &&
                    !answered_q && !hit_now;
  assign miss_now = key_miss || timeout;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d     = state_q;
    cnt_d       = running ? (beat ? '0 : cnt_q + 1'b1) : '0;
    cd_d        = cd_q;
    song_addr_d = song_addr_q;
    expected_d  = expected_q;
    answered_d  = answered_q;
    score_d     = score_q;
    lives_d     = lives_q;
    hit_d       = 1'b0;
    miss_d      = 1'b0;

    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (bus.start) begin
          score_d     = '0;
          lives_d     = 2'(LIVES_INIT);
          song_addr_d = '0;
          expected_d  = EMPTY;
          answered_d  = 1'b0;
          cnt_d       = '0;
          cd_d        = '0;
          state_d     = S_COUNTDOWN;
        end
      end

      S_COUNTDOWN: begin
        if (beat) begin
          if (cd_q == CDW'(COUNTDOWN_BEATS - 1)) begin
            expected_d  = bus.song_data;
            song_addr_d = 7'd1;
            answered_d  = 1'b0;
            cd_d        = '0;
            state_d     = S_PLAY;
          end else begin
            cd_d = cd_q + 1'b1;
          end
        end
      end

      S_PLAY: begin
        if (hit_now) begin
          score_d    = (score_q == 10'd1023) ? score_q : score_q + 1'b1;
          answered_d = 1'b1;
          hit_d      = 1'b1;
        end
        if (miss_now) begin
          miss_d  = 1'b1;
          lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 1'b1;
        end
        // Running out of lives ends the round ahead of any song advance.
        if (miss_now && (lives_q <= 2'd1)) begin
          state_d    = S_OVER;
          expected_d = EMPTY;
          cnt_d      = '0;
        end else if (beat) begin
          if (song_addr_q == 7'(SONG_LEN)) begin
            state_d    = S_OVER;
            expected_d = EMPTY;
            cnt_d      = '0;
          end else begin
            expected_d  = bus.song_data;
            song_addr_d = song_addr_q + 1'b1;
            answered_d  = 1'b0;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cd_q        <= '0;
      song_addr_q <= '0;
      expected_q  <= EMPTY;
      answered_q  <= 1'b0;
      score_q     <= '0;
      lives_q     <= 2'(LIVES_INIT);
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cd_q        <= cd_d;
      song_addr_q <= song_addr_d;
      expected_q  <= expected_d;
      answered_q  <= answered_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
    end
  end

  assign bus.song_addr  = song_addr_q;
  assign bus.expected   = expected_q;
  assign bus.state      = state_q;
  assign bus.score      = score_q;
  assign bus.lives      = lives_q;
  assign bus.hit_pulse  = hit_q;
  assign bus.miss_pulse = miss_q;
  assign bus.won        = (state_q == S_OVER) && (lives_q != 2'd0);

endmodule

// File: tb/tb_tile_game_ctrl.sv
// Directed bench for tile_game_ctrl: short beats, 4-tile song {1C,1B,05,23}, two lives.
module tb_tile_game_ctrl;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  logic [7:0] rom [0:7];

  tile_game_if bus ();

  tile_game_ctrl #(
    .TICK_CYCLES    (4),
    .SONG_LEN       (4),
    .LIVES_INIT     (2),
    .COUNTDOWN_BEATS(2),
    .EMPTY          (8'h05)
  ) dut (
    .CLOCK_50(clk),
    .reset   (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM model, one cycle of read latency.
  always @(posedge clk) bus.song_data <= rom[bus.song_addr[2:0]];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [7:0] code);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    tick(1);
    bus.key_valid = 1'b0;
    bus.key_code  = 8'h00;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rom[0] = 8'h1C; rom[1] = 8'h1B; rom[2] = 8'h05; rom[3] = 8'h23;
    for (int i = 4; i < 8; i++) rom[i] = 8'h05;
    bus.start     = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_code  = 8'h00;
    rst_n = 1'b0;
    tick(2);
    check("rst_state",    16'(bus.state), 16'd0);
    check("rst_score",    16'(bus.score), 16'd0);
    check("rst_lives",    16'(bus.lives), 16'd2);
    check("rst_addr",     16'(bus.song_addr), 16'd0);
    check("rst_expected", 16'(bus.expected), 16'h05);
    check("rst_pulses",   {14'd0, bus.hit_pulse, bus.miss_pulse}, 16'd0);
    check("rst_won",      16'(bus.won), 16'd0);
    rst_n = 1'b1;
    tick(1);
    check("idle_hold", 16'(bus.state), 16'd0);

    // Game A: hit, wrong key on a beat (single life), silent EMPTY window, hit on final beat.
    pulse_start();
    check("a_countdown", 16'(bus.state), 16'd1);
    tick(8);
    check("a_play",      16'(bus.state), 16'd2);
    check("a_exp0",      16'(bus.expected), 16'h1C);
    check("a_addr1",     16'(bus.song_addr), 16'd1);
    press(8'h1C);
    check("a_hit_pulse", 16'(bus.hit_pulse), 16'd1);
    check("a_score1",    16'(bus.score), 16'd1);
    tick(3);
    check("a_exp1",      16'(bus.expected), 16'h1B);
    check("a_no_miss0",  16'(bus.miss_pulse), 16'd0);
    tick(3);
    press(8'h1C);
    check("a_wrong_beat_miss",  16'(bus.miss_pulse), 16'd1);
    check("a_wrong_beat_lives", 16'(bus.lives), 16'd1);
    check("a_exp2",             16'(bus.expected), 16'h05);
    tick(4);
    check("a_empty_no_miss", 16'(bus.miss_pulse), 16'd0);
    check("a_empty_lives",   16'(bus.lives), 16'd1);
    check("a_exp3",          16'(bus.expected), 16'h23);
    check("a_addr4",         16'(bus.song_addr), 16'd4);
    tick(3);
    press(8'h23);
    check("a_final_hit",   16'(bus.hit_pulse), 16'd1);
    check("a_final_nomiss",16'(bus.miss_pulse), 16'd0);
    check("a_final_score", 16'(bus.score), 16'd2);
    check("a_over",        16'(bus.state), 16'd3);
    check("a_won",         16'(bus.won), 16'd1);

    // Game B: restart from OVER, plain timeout, press on EMPTY ends the round.
    pulse_start();
    check("b_countdown", 16'(bus.state), 16'd1);
    check("b_score0",    16'(bus.score), 16'd0);
    check("b_lives2",    16'(bus.lives), 16'd2);
    check("b_addr0",     16'(bus.song_addr), 16'd0);
    tick(8);
    check("b_exp0",      16'(bus.expected), 16'h1C);
    press(8'h1C);
    check("b_score1",    16'(bus.score), 16'd1);
    tick(3);
    check("b_exp1",      16'(bus.expected), 16'h1B);
    check("b_no_miss0",  16'(bus.miss_pulse), 16'd0);
    tick(4);
    check("b_timeout_miss",  16'(bus.miss_pulse), 16'd1);
    check("b_timeout_lives", 16'(bus.lives), 16'd1);
    check("b_exp2",          16'(bus.expected), 16'h05);
    press(8'h1C);
    check("b_empty_miss", 16'(bus.miss_pulse), 16'd1);
    check("b_lives0",     16'(bus.lives), 16'd0);
    check("b_over",       16'(bus.state), 16'd3);
    check("b_lost",       16'(bus.won), 16'd0);
    press(8'h1B);
    check("b_over_ignore", {14'd0, bus.hit_pulse, bus.miss_pulse}, 16'd0);
    check("b_over_score",  16'(bus.score), 16'd1);
    pulse_start();
    check("b_restart_state", 16'(bus.state), 16'd1);
    check("b_restart_score", 16'(bus.score), 16'd0);
    check("b_restart_lives", 16'(bus.lives), 16'd2);

    // Game C: second press in a window, then asynchronous reset mid-PLAY.
    tick(8);
    check("c_play", 16'(bus.state), 16'd2);
    press(8'h1C);
    check("c_score1", 16'(bus.score), 16'd1);
    press(8'h1C);
    check("c_double_miss",  16'(bus.miss_pulse), 16'd1);
    check("c_double_lives", 16'(bus.lives), 16'd1);
    tick(2);
    check("c_addr2", 16'(bus.song_addr), 16'd2);
    check("c_exp1",  16'(bus.expected), 16'h1B);
    rst_n = 1'b0;
    #2;
    check("c_async_state", 16'(bus.state), 16'd0);
    check("c_async_score", 16'(bus.score), 16'd0);
    check("c_async_lives", 16'(bus.lives), 16'd2);
    check("c_async_exp",   16'(bus.expected), 16'h05);
    check("c_async_addr",  16'(bus.song_addr), 16'd0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    check("c_post_idle", 16'(bus.state), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
